dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//   Shares the single DataMem port between two bus masters: M0 (CPU data port, via NorthBridge) and M1 (DMA/debug master).
//   Registered req/gnt handshake, round-robin on ties, optional locked bursts capped at MAX_BURST beats.
//   Sits between NorthBridge DM_* outputs and DataMem; DataMem reads combinationally and writes on clk edge.
// PARAMETERS
//   MAX_BURST   8   max consecutive beats one owner holds the port under lock (1..255)
//   FIRST_PRI   0   master that wins the first tie after reset (0 or 1)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   m0_req     in   1   M0 requests a beat this cycle
//   m0_lock    in   1   M0 wants to keep the port after this beat
//   m0_pc      in   32  PC tag of M0 access (passed to DataMem for logging)
//   m0_addr    in   32  M0 byte address
//   m0_wdata   in   32  M0 write data
//   m0_we      in   4   M0 byte write enables (0 = read)
//   m0_gnt     out  1   M0 owns the port; beat completes when m0_req & m0_gnt
//   m0_rdata   out  32  read data to M0 (0 when not owner)
//   m1_*       --   --  identical set for M1 (m1_req, m1_lock, m1_pc, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rdata)
//   dm_pc      out  32  PC tag to DataMem
//   dm_addr    out  32  address to DataMem
//   dm_wdata   out  32  write data to DataMem
//   dm_we      out  4   byte write enables to DataMem
//   dm_rdata   in   32  read data from DataMem
//   busy       out  1   port owned (state != IDLE)
// BEHAVIOUR
//   Reset: state=IDLE, last_owner=~FIRST_PRI, beat_cnt=0; m0_gnt=m1_gnt=0, busy=0, dm_*=0, m*_rdata=0.
//   dm_we forced 0 combinationally in any cycle reset is high (no write during reset, even mid-burst).
//   States: IDLE, OWN0, OWN1. gnt_x = (state==OWNx), registered; dm_* mux combinational from owner's inputs.
//   IDLE/non-owned cycles: dm_addr/wdata/pc=0, dm_we=0; request in cycle N -> gnt earliest in N+1 (1-cycle latency).
//   Beat: cycle where owner's req=1 in OWNx; DataMem write occurs on that edge, read data valid same cycle.
//   Owner with req=0 in OWNx: no beat, dm_we=0, port released at edge (treated as end of tenure).
//   Arbitration point = IDLE cycle, or OWNx cycle where tenure ends:
//     tenure ends if req_x=0, or beat with lock_x=0, or beat with beat_cnt==MAX_BURST-1.
//   Winner at arbitration point (evaluated on current req inputs, incl. outgoing owner's req):
//     only one requester -> it; both -> master != last_owner; none -> IDLE.
//     Outgoing owner may win back only if other master not requesting; back-to-back handover has no idle cycle.
//   On entering OWNx from a tenure end or IDLE: last_owner<=x, beat_cnt<=0. Each beat otherwise beat_cnt<=beat_cnt+1 (8-bit, never wraps: capped by MAX_BURST).
//   lock ignored on non-beat cycles; lock without req has no effect.
//   Non-owner inputs ignored entirely; non-owner rdata=0, gnt=0.
//   m*_we nonzero with req=0 never reaches dm_we.
// TESTING
//   1) Reset, m0_req=1 single read addr 0x10 -> m0_gnt=1 next cycle, dm_addr=0x10, m0_rdata=dm_rdata, dm_we=0; m1_rdata=0.
//   2) Both req unlocked from reset (FIRST_PRI=0), held 4 cycles -> gnt sequence M0,M1,M0,M1, no idle gaps.
//   3) M0 lock=1 req=1 continuous, M1 req=1, MAX_BURST=8 -> M0 gets exactly 8 beats, then M1 gnt next cycle.
//   4) M0 write 0xDEADBEEF to 0x20 we=4'b0011, M1 req simultaneously while M0 owns -> dm_we=4'b0011 only in M0 beat; M1 write delayed, data at 0x20 low half=0xBEEF.
//   5) Reset asserted mid M1 locked burst with m1_we=4'hF -> dm_we=0 that cycle, next cycle IDLE, gnts=0, busy=0.
//   6) Owner drops req without lock while other idle -> next cycle IDLE, dm_*=0; re-req -> 1-cycle grant latency.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_port_arbiter_if                                        |
// | Purpose  : Bundle of the two master request ports and the DataMem    |
// |            port that the DataMem arbiter shares between them.         |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface dm_port_arbiter_if;
  // Master 0 (CPU data port via NorthBridge)
  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_pc;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_we;
  logic        m0_gnt;
  logic [31:0] m0_rdata;
  // Master 1 (DMA / debug master)
  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_pc;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_we;
  logic        m1_gnt;
  logic [31:0] m1_rdata;
  // DataMem side
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_we;
  logic [31:0] dm_rdata;
  logic        busy;

  // Arbiter view
  modport slave (
    input  m0_req, m0_lock, m0_pc, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_lock, m1_pc, m1_addr, m1_wdata, m1_we,
    input  dm_rdata,
    output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    output dm_pc, dm_addr, dm_wdata, dm_we, busy
  );

  // Environment view (masters plus DataMem)
  modport master (
    output m0_req, m0_lock, m0_pc, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_lock, m1_pc, m1_addr, m1_wdata, m1_we,
    output dm_rdata,
    input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    input  dm_pc, dm_addr, dm_wdata, dm_we, busy
  );
endinterface
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_port_arbiter                                           |
// | Purpose  : Two-master arbiter for the single DataMem port. Registered |
// |            grants, round-robin on ties, locked bursts of at most      |
// |            MAX_BURST beats.                                           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dm_port_arbiter #(
  parameter int MAX_BURST = 8,     // 1..255 beats per locked tenure
  parameter bit FIRST_PRI = 1'b0   // winner of the first tie after reset
) (
  input  logic clk,
  input  logic reset,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t      state;
  logic        last_owner;
  logic [7:0]  beat_cnt;

  logic        own0;
  logic        own1;
  logic        owner_req;
  logic        owner_lock;
  logic        arb_point;
  logic        winner_valid;
  logic        winner;

  // Decide whether this cycle is an arbitration point and who wins it.
  // The outgoing owner competes on its live req, but a simultaneous request
  // from the other master wins because last_owner still names the outgoing one.
  always_comb begin
    own0       = (state == OWN0);
    own1       = (state == OWN1);
    owner_req  = (own0 & bus.m0_req)  | (own1 & bus.m1_req);
    owner_lock = (own0 & bus.m0_lock) | (own1 & bus.m1_lock);
    arb_point  = (state == IDLE) | ~owner_req |
                 (owner_req & (~owner_lock | (beat_cnt == LAST_BEAT)));
    winner_valid = bus.m0_req | bus.m1_req;
    winner       = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      winner = ~last_owner;
    end else if (bus.m1_req) begin
      winner = 1'b1;
    end
  end

  // Ownership state, round-robin history and burst length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= ~FIRST_PRI;
      beat_cnt   <= 8'd0;
    end else if (arb_point) begin
      beat_cnt <= 8'd0;
      if (winner_valid) begin
        state      <= winner ? OWN1 : OWN0;
        last_owner <= winner;
      end else begin
        state <= IDLE;
      end
    end else begin
      // Locked beat below the cap: counter cannot pass LAST_BEAT, so no wrap.
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign bus.m0_gnt = own0;
  assign bus.m1_gnt = own1;
  assign bus.busy   = (state != IDLE);

  // Steer the owner's request onto DataMem; writes only on a real beat and
  // never while reset is asserted, even in the middle of a burst.
  always_comb begin
    bus.dm_pc    = 32'd0;
    bus.dm_addr  = 32'd0;
    bus.dm_wdata = 32'd0;
    bus.dm_we    = 4'd0;
    bus.m0_rdata = 32'd0;
    bus.m1_rdata = 32'd0;
    if (own0) begin
      bus.dm_pc    = bus.m0_pc;
      bus.dm_addr  = bus.m0_addr;
      bus.dm_wdata = bus.m0_wdata;
      bus.dm_we    = (bus.m0_req && !reset) ? bus.m0_we : 4'd0;
      bus.m0_rdata = bus.dm_rdata;
    end else if (own1) begin
      bus.dm_pc    = bus.m1_pc;
      bus.dm_addr  = bus.m1_addr;
      bus.dm_wdata = bus.m1_wdata;
      bus.dm_we    = (bus.m1_req && !reset) ? bus.m1_we : 4'd0;
      bus.m1_rdata = bus.dm_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dm_port_arbiter                                        |
// | Purpose  : Self-checking bench for dm_port_arbiter: directed cases    |
// |            plus randomized traffic against a tenure-level model.      |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dm_port_arbiter;

  localparam int MAX_BURST = 8;
  localparam bit FIRST_PRI = 1'b0;

  logic clk;
  logic reset;
  dm_port_arbiter_if bus ();

  dm_port_arbiter #(
    .MAX_BURST (MAX_BURST),
    .FIRST_PRI (FIRST_PRI)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small DataMem: combinational read, byte-enabled write on the clock edge.
  logic [31:0] mem [16];
  assign bus.dm_rdata = mem[bus.dm_addr[5:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.dm_we[b]) mem[bus.dm_addr[5:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, who owned it last, beats taken in tenure.
  int exp_owner = -1;
  int exp_last  = 1;
  int exp_beats = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks every output against the model, then advances the model one edge.
  task automatic cycle();
    logic [31:0] e_addr, e_pc, e_wd, e_rd;
    logic [3:0]  e_we;
    logic        oreq, olock;
    int          nxt;
    bit          keep;
    #1;
    oreq  = (exp_owner == 0) ? bus.m0_req  : (exp_owner == 1) ? bus.m1_req  : 1'b0;
    olock = (exp_owner == 0) ? bus.m0_lock : (exp_owner == 1) ? bus.m1_lock : 1'b0;
    e_addr = (exp_owner == 0) ? bus.m0_addr  : (exp_owner == 1) ? bus.m1_addr  : 32'd0;
    e_pc   = (exp_owner == 0) ? bus.m0_pc    : (exp_owner == 1) ? bus.m1_pc    : 32'd0;
    e_wd   = (exp_owner == 0) ? bus.m0_wdata : (exp_owner == 1) ? bus.m1_wdata : 32'd0;
    e_we   = (reset || !oreq) ? 4'd0 : (exp_owner == 0) ? bus.m0_we : bus.m1_we;
    e_rd   = mem[e_addr[5:2]];
    check("m0_gnt", {31'd0, bus.m0_gnt}, {31'd0, exp_owner == 0});
    check("m1_gnt", {31'd0, bus.m1_gnt}, {31'd0, exp_owner == 1});
    check("busy",   {31'd0, bus.busy},   {31'd0, exp_owner >= 0});
    check("dm_addr",  bus.dm_addr,  e_addr);
    check("dm_pc",    bus.dm_pc,    e_pc);
    check("dm_wdata", bus.dm_wdata, e_wd);
    check("dm_we",    {28'd0, bus.dm_we}, {28'd0, e_we});
    check("m0_rdata", bus.m0_rdata, (exp_owner == 0) ? e_rd : 32'd0);
    check("m1_rdata", bus.m1_rdata, (exp_owner == 1) ? e_rd : 32'd0);
    @(posedge clk);
    if (reset) begin
      exp_owner = -1;
      exp_last  = FIRST_PRI ? 0 : 1;
      exp_beats = 0;
    end else begin
      keep = 1'b0;
      if (exp_owner >= 0 && oreq) begin
        exp_beats++;
        keep = olock && (exp_beats < MAX_BURST);
      end
      if (!keep) begin
        if (bus.m0_req && bus.m1_req) nxt = 1 - exp_last;
        else if (bus.m0_req)          nxt = 0;
        else if (bus.m1_req)          nxt = 1;
        else                          nxt = -1;
        exp_owner = nxt;
        if (nxt >= 0) exp_last = nxt;
        exp_beats = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_pc = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_we = 0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_pc = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_we = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  bit exp_g0 [5] = '{0, 1, 0, 1, 0};
  bit exp_g1 [5] = '{0, 0, 1, 0, 1};

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | (i << 2);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_owner = -1; exp_last = FIRST_PRI ? 0 : 1; exp_beats = 0;
    reset = 1'b0;

    // 1) single read by M0
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    check("t1_no_gnt_yet", {31'd0, bus.m0_gnt}, 32'd0);
    cycle();
    check("t1_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("t1_addr", bus.dm_addr, 32'h10);
    check("t1_rdata", bus.m0_rdata, 32'hA5A5_0010);
    check("t1_m1_rdata", bus.m1_rdata, 32'd0);
    cycle();

    // 2) both unlocked: alternate with no idle gap
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1;
    for (int i = 0; i < 5; i++) begin
      check("t2_g0", {31'd0, bus.m0_gnt}, {31'd0, exp_g0[i]});
      check("t2_g1", {31'd0, bus.m1_gnt}, {31'd0, exp_g1[i]});
      cycle();
    end

    // 3) M0 locked burst capped at MAX_BURST beats
    do_reset();
    bus.m0_req = 1; bus.m0_lock = 1; bus.m1_req = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m1_gnt) break;
      if (bus.m0_gnt) n++;
      cycle();
    end
    check("t3_beats", n, MAX_BURST);
    check("t3_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    cycle();

    // 4) M0 partial write while M1 waits
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'hDEAD_BEEF; bus.m0_we = 4'b0011;
    cycle();
    bus.m1_req = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h1234_5678; bus.m1_we = 4'hF;
    #1 check("t4_we_m0", {28'd0, bus.dm_we}, 32'h3);
    cycle();
    bus.m0_req = 0; bus.m0_we = 0;
    check("t4_mem_low", {16'd0, mem[8][15:0]}, 32'hBEEF);
    check("t4_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    cycle();
    bus.m1_req = 0;
    cycle();

    // 5) reset in the middle of a locked M1 write burst
    do_reset();
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_we = 4'hF; bus.m1_addr = 32'h3C; bus.m1_wdata = 32'hCAFE_F00D;
    repeat (3) cycle();
    reset = 1'b1;
    #1 check("t5_we_in_reset", {28'd0, bus.dm_we}, 32'd0);
    cycle();
    reset = 1'b0; idle_inputs();
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_gnt", {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd0);
    cycle();

    // 6) owner drops req, then re-requests
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h8;
    cycle();
    bus.m0_req = 0;
    cycle();
    check("t6_idle_addr", bus.dm_addr, 32'd0);
    bus.m0_req = 1;
    cycle();
    check("t6_regrant", {31'd0, bus.m0_gnt}, 32'd1);
    cycle();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 79) == 0);
      bus.m0_req   = ($urandom_range(0, 3) != 0);
      bus.m1_req   = ($urandom_range(0, 2) != 0);
      bus.m0_lock  = ($urandom_range(0, 3) != 0);
      bus.m1_lock  = ($urandom_range(0, 1) != 0);
      bus.m0_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bus.m1_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bus.m0_pc    = $urandom;
      bus.m1_pc    = $urandom;
      bus.m0_wdata = $urandom;
      bus.m1_wdata = $urandom;
      bus.m0_we    = 4'($urandom);
      bus.m1_we    = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
